jtframe_dwnld_pack: RTL and testbench

- Sits between the SPI download port (ioctl_addr/ioctl_data/ioctl_wr/downloading) and the SDRAM programming port (prog_addr/prog_data/prog_mask/prog_bank/prog_we).
- Buffers the incoming ROM byte stream in a small FIFO and maps each byte's linear address to an SDRAM bank and a 16-bit word address.
- Issues one write at a time to the SDRAM controller using a we/ack handshake.
- Drives dwnld_busy, which the framework uses to hold the game in reset until every byte has landed in SDRAM.

---
 rtl/jtframe_dwnld_pack.sv | 185 ++++++++++++++++++
 tb/tb_jtframe_dwnld_pack.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dwnld_pack.sv
// Download packer: buffers ioctl bytes in a small FIFO, maps them to SDRAM bank/word/lane
// and writes them one at a time over a we/ack handshake. Optional JTFRAME_DWNLD_HEADER_EN skips a leading header.
module jtframe_dwnld_pack #(
  parameter int          AW        = 3,
  parameter logic [24:0] BA1_START = 25'h100000,
  parameter logic [24:0] BA2_START = 25'h200000,
  parameter logic [24:0] BA3_START = 25'h300000,
  parameter int          POST_CNT  = 16,
  parameter int          HEADER    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  input  logic        prog_ack,
  output logic        dwnld_busy,
  output logic        ovf
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = (POST_CNT > 0) ? $clog2(POST_CNT + 1) : 1;
  localparam logic [24:0] HDR = 25'(HEADER);
`ifdef JTFRAME_DWNLD_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  bank;
    logic [21:0] word;
    logic        lane;
    logic [7:0]  data;
  } entry_t;

  state_t      st, st_nxt;
  entry_t      mem [DEPTH];
  entry_t      in_entry, head;
  logic [AW:0] wr_ptr, rd_ptr, fill;
  logic        full, empty, wr_ok, push, drop, pop;
  logic        hdr_skip, dl_q, dl_rise, quiet;
  logic [24:0] eff_addr;
  logic [1:0]  in_bank;
  logic [22:0] in_off;
  logic [CW-1:0] post_cnt;

  logic        we_nxt;
  logic [1:0]  mask_nxt, bank_nxt;
  logic [21:0] addr_nxt;
  logic [7:0]  data_nxt;

  // Header bytes vanish entirely: they neither enter the FIFO nor count as overflow.
  assign hdr_skip = HDR_EN && (ioctl_addr < HDR);
  assign eff_addr = HDR_EN ? (ioctl_addr - HDR) : ioctl_addr;

  always_comb begin
    in_bank = 2'd0;
    in_off  = eff_addr[22:0];
    if (eff_addr >= BA3_START) begin
      in_bank = 2'd3;
      in_off  = 23'(eff_addr - BA3_START);
    end else if (eff_addr >= BA2_START) begin
      in_bank = 2'd2;
      in_off  = 23'(eff_addr - BA2_START);
    end else if (eff_addr >= BA1_START) begin
      in_bank = 2'd1;
      in_off  = 23'(eff_addr - BA1_START);
    end
  end

  assign in_entry = {in_bank, in_off[22:1], in_off[0], ioctl_data};

  // Full/empty come from the registered pointers, so a same-cycle pop never frees a slot early.
  assign fill  = wr_ptr - rd_ptr;
  assign full  = (fill == (AW+1)'(DEPTH));
  assign empty = (fill == '0);
  assign wr_ok = ioctl_wr && downloading && !hdr_skip;
  assign push  = wr_ok && !full;
  assign drop  = wr_ok && full;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    st_nxt   = st;
    we_nxt   = prog_we;
    mask_nxt = prog_mask;
    bank_nxt = prog_bank;
    addr_nxt = prog_addr;
    data_nxt = prog_data;
    pop      = 1'b0;
    case (st)
      IDLE: begin
        if (!empty) begin
          bank_nxt = head.bank;
          addr_nxt = head.word;
          data_nxt = head.data;
          mask_nxt = head.lane ? 2'b01 : 2'b10;
          we_nxt   = 1'b1;
          st_nxt   = WRITE;
        end
      end
      WRITE: begin
        if (prog_ack) begin
          pop      = 1'b1;
          we_nxt   = 1'b0;
          mask_nxt = 2'b11;
          st_nxt   = GAP;
        end
      end
      GAP:     st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      prog_we   <= 1'b0;
      prog_mask <= 2'b11;
      prog_bank <= 2'd0;
      prog_addr <= '0;
      prog_data <= '0;
    end else begin
      st        <= st_nxt;
      prog_we   <= we_nxt;
      prog_mask <= mask_nxt;
      prog_bank <= bank_nxt;
      prog_addr <= addr_nxt;
      prog_data <= data_nxt;
    end
  end

  // The tail counter only runs once nothing is left anywhere in the path to SDRAM.
  assign dl_rise = downloading && !dl_q;
  assign quiet   = !downloading && empty && (st == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q       <= 1'b0;
      dwnld_busy <= 1'b0;
      post_cnt   <= '0;
      ovf        <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (dl_rise) begin
        dwnld_busy <= 1'b1;
        post_cnt   <= CW'(POST_CNT);
      end else if (push) begin
        post_cnt <= CW'(POST_CNT);
      end else if (quiet) begin
        if (post_cnt == '0) dwnld_busy <= 1'b0;
        else                post_cnt   <= post_cnt - 1'b1;
      end
      if (drop)         ovf <= 1'b1;
      else if (dl_rise) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Bench for jtframe_dwnld_pack: a queue-based model of the byte-to-SDRAM path checked every cycle,
// plus literal write tuples and tail timing for the directed scenarios.
module tb_jtframe_dwnld_pack;
  localparam int DEPTH    = 8;
  localparam int POST_CNT = 16;
  localparam int HEADER   = 16;
`ifdef JTFRAME_DWNLD_HEADER_EN
  localparam int HOFS = HEADER;
`else
  localparam int HOFS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        prog_ack = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_bank;
  logic        prog_we;
  logic        dwnld_busy;
  logic        ovf;

  jtframe_dwnld_pack #(
    .AW(3), .POST_CNT(POST_CNT), .HEADER(HEADER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_bank(prog_bank), .prog_we(prog_we), .prog_ack(prog_ack),
    .dwnld_busy(dwnld_busy), .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: entries are {bank, word address, mask, data}
  logic [33:0] exp_q[$];
  logic [33:0] wlog[$];
  int  m_occ = 0, m_quiet = 0;
  bit  m_we = 0, m_gap = 0, m_busy = 0, m_ovf = 0, m_dl_prev = 0;
  bit  we_prev = 0, busy_prev = 0;
  int  ack_edge_last = -1, busy_fall_edge = -1;

  function automatic logic [33:0] expected_entry(input logic [24:0] a, input logic [7:0] d);
    int unsigned ea, off;
    logic [1:0]  b;
    ea = a;
`ifdef JTFRAME_DWNLD_HEADER_EN
    ea = ea - HEADER;
`endif
    if (ea >= 32'h300000)      begin b = 2'd3; off = ea - 32'h300000; end
    else if (ea >= 32'h200000) begin b = 2'd2; off = ea - 32'h200000; end
    else if (ea >= 32'h100000) begin b = 2'd1; off = ea - 32'h100000; end
    else                       begin b = 2'd0; off = ea; end
    return {b, 22'(off / 2), (off % 2 == 1) ? 2'b01 : 2'b10, d};
  endfunction

  function automatic bit header_byte(input logic [24:0] a);
`ifdef JTFRAME_DWNLD_HEADER_EN
    return a < HEADER;
`else
    return 1'b0;
`endif
  endfunction

  // Compare at negedge (state after the last rising edge), then advance the model
  // by the rising edge that follows, using the inputs currently applied.
  always @(negedge clk) begin : compare
    logic [33:0] act;
    bit ack_take, rise, quiet, next_we;
    if (!rst_n) begin
      exp_q.delete();
      m_occ = 0; m_quiet = 0; m_we = 0; m_gap = 0;
      m_busy = 0; m_ovf = 0; m_dl_prev = 0;
      we_prev = 0; busy_prev = 0;
    end else begin
      act = {prog_bank, prog_addr, prog_mask, prog_data};
      chk("prog_we", {33'd0, prog_we}, {33'd0, m_we});
      chk("dwnld_busy", {33'd0, dwnld_busy}, {33'd0, m_busy});
      chk("ovf", {33'd0, ovf}, {33'd0, m_ovf});
      if (m_we && exp_q.size() > 0) chk("write_fields", act, exp_q[0]);
      else if (!m_we) chk("prog_mask_idle", {32'd0, prog_mask}, 34'd3);
      if (prog_we && !we_prev) wlog.push_back(act);
      we_prev = prog_we;
      if (busy_prev && !dwnld_busy) busy_fall_edge = cyc;
      busy_prev = dwnld_busy;

      ack_take = prog_ack && m_we;
      if (ack_take) ack_edge_last = cyc + 1;
      rise    = downloading && !m_dl_prev;
      quiet   = !downloading && (m_occ == 0) && !m_gap;
      next_we = m_we ? !ack_take : ((m_occ > 0) && !m_gap);
      if (rise) m_ovf = 0;
      if (ioctl_wr && downloading && !header_byte(ioctl_addr)) begin
        if (m_occ == DEPTH) m_ovf = 1;
        else begin
          exp_q.push_back(expected_entry(ioctl_addr, ioctl_data));
          m_occ++;
        end
      end
      if (ack_take) begin
        void'(exp_q.pop_front());
        m_occ--;
      end
      // busy drops on the (POST_CNT+1)-th consecutive quiet edge
      if (rise) begin
        m_busy = 1; m_quiet = 0;
      end else if (quiet) begin
        if (m_quiet == POST_CNT) m_busy = 0;
        else m_quiet++;
      end else m_quiet = 0;
      m_we = next_we; m_gap = ack_take; m_dl_prev = downloading;
    end
  end

  // ack responder
  int ack_delay = 1;
  bit ack_hold = 0;
  bit stray_req = 0;
  int ack_wait = 0;
  initial forever begin
    @(posedge clk); #1;
    if (prog_ack) begin
      prog_ack = 1'b0; ack_wait = 0;
    end else if (stray_req) begin
      prog_ack = 1'b1; stray_req = 0;
    end else if (prog_we && !ack_hold) begin
      if (ack_wait >= ack_delay) prog_ack = 1'b1;
      else ack_wait++;
    end else ack_wait = 0;
  end

  // driver tasks
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic set_dl(input bit v);
    @(posedge clk); #1;
    downloading = v;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    bit done;
    done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_we && !m_gap) done = 1;
    end
    chk(name, {33'd0, done}, 34'd1);
    repeat (2) @(posedge clk);
  endtask

  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_we", {33'd0, prog_we}, 34'd0);
    chk("reset_mask", {32'd0, prog_mask}, 34'd3);
    chk("reset_busy", {33'd0, dwnld_busy}, 34'd0);
    chk("reset_ovf", {33'd0, ovf}, 34'd0);
    chk("reset_fields", {prog_bank, prog_addr, 2'b00, prog_data}, 34'd0);

    set_dl(1);
    repeat (2) @(negedge clk);
    chk("busy_on_rise", {33'd0, dwnld_busy}, 34'd1);

    // basic mapping, ack two cycles after we
    base = wlog.size();
    ack_delay = 1;
    send_byte(25'(HOFS + 0), 8'hA5);
    send_byte(25'(HOFS + 1), 8'h5A);
    wait_drain("drain_basic", 100);
    chk("basic_count", 34'(wlog.size() - base), 34'd2);
    chk("basic_w0", wlog[base],     {2'd0, 22'd0, 2'b10, 8'hA5});
    chk("basic_w1", wlog[base + 1], {2'd0, 22'd0, 2'b01, 8'h5A});

    // bank boundaries
    base = wlog.size();
    send_byte(25'(HOFS + 32'h100003), 8'h55);
    send_byte(25'(HOFS + 32'h30000A), 8'h66);
    send_byte(25'(HOFS + 32'h0FFFFF), 8'h77);
    wait_drain("drain_banks", 100);
    chk("bank1", wlog[base],     {2'd1, 22'd1, 2'b01, 8'h55});
    chk("bank3", wlog[base + 1], {2'd3, 22'd5, 2'b10, 8'h66});
    chk("bank0_top", wlog[base + 2], {2'd0, 22'h7FFFF, 2'b01, 8'h77});

    // back-to-back with immediate ack
    base = wlog.size();
    ack_delay = 0;
    for (int i = 0; i < 4; i++) send_byte(25'(HOFS + 32'h200000 + i), 8'(8'h10 + i));
    wait_drain("drain_fast", 100);
    chk("fast_w0", wlog[base],     {2'd2, 22'd0, 2'b10, 8'h10});
    chk("fast_w3", wlog[base + 3], {2'd2, 22'd1, 2'b01, 8'h13});

    // overflow: 10 bytes into 8 slots while ack is withheld
    base = wlog.size();
    ack_hold = 1;
    for (int i = 0; i < 10; i++) send_byte(25'(HOFS + 32'h40 + i), 8'(8'h80 + i));
    @(negedge clk);
    chk("ovf_set", {33'd0, ovf}, 34'd1);
    ack_hold = 0;
    wait_drain("drain_ovf", 200);
    chk("ovf_count", 34'(wlog.size() - base), 34'd8);
    chk("ovf_first", wlog[base],     {2'd0, 22'h20, 2'b10, 8'h80});
    chk("ovf_last",  wlog[base + 7], {2'd0, 22'h23, 2'b01, 8'h87});
    chk("ovf_held", {33'd0, ovf}, 34'd1);
    set_dl(0);
    repeat (3) @(posedge clk);
    set_dl(1);
    repeat (2) @(negedge clk);
    chk("ovf_cleared", {33'd0, ovf}, 34'd0);

    // busy tail: ack edge of the 3rd write, GAP edge, then 17 quiet edges
    base = wlog.size();
    ack_hold = 1;
    for (int i = 0; i < 3; i++) send_byte(25'(HOFS + 32'h500 + i), 8'(8'hC0 + i));
    set_dl(0);
    repeat (5) @(posedge clk);
    chk("tail_busy_held", {33'd0, dwnld_busy}, 34'd1);
    busy_fall_edge = -1;
    ack_hold = 0;
    for (int i = 0; i < 200 && busy_fall_edge < 0; i++) @(negedge clk);
    chk("tail_writes", 34'(wlog.size() - base), 34'd3);
    chk("tail_len", 34'(busy_fall_edge - ack_edge_last), 34'd18);

    // stray ack while idle must not start anything
    base = wlog.size();
    stray_req = 1;
    repeat (5) @(posedge clk);
    chk("stray_ack", 34'(wlog.size() - base), 34'd0);

`ifdef JTFRAME_DWNLD_HEADER_EN
    set_dl(1);
    base = wlog.size();
    for (int i = 0; i < HEADER; i++) send_byte(25'(i), 8'(i));
    send_byte(25'(HEADER), 8'hC3);
    wait_drain("drain_header", 100);
    chk("header_count", 34'(wlog.size() - base), 34'd1);
    chk("header_first", wlog[base], {2'd0, 22'd0, 2'b10, 8'hC3});
    chk("header_no_ovf", {33'd0, ovf}, 34'd0);
`endif

    // reset in the middle of a write
    set_dl(1);
    ack_hold = 1;
    send_byte(25'(HOFS + 32'h600), 8'hE0);
    send_byte(25'(HOFS + 32'h601), 8'hE1);
    repeat (2) @(negedge clk);
    chk("pre_reset_we", {33'd0, prog_we}, 34'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    downloading = 1'b0;
    #1;
    chk("rst_we", {33'd0, prog_we}, 34'd0);
    chk("rst_mask", {32'd0, prog_mask}, 34'd3);
    chk("rst_busy", {33'd0, dwnld_busy}, 34'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ack_hold = 0;
    base = wlog.size();
    repeat (20) @(posedge clk);
    chk("rst_no_write", 34'(wlog.size() - base), 34'd0);
    @(negedge clk);
    chk("rst_busy_low", {33'd0, dwnld_busy}, 34'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
